// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register sequencer: FSM states, response codes,
// R/W address bit and the captured request record.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_S_ADDR_W  = 3'd1;
    localparam logic [2:0] ST_W_REG     = 3'd2;
    localparam logic [2:0] ST_W_DATA    = 3'd3;
    localparam logic [2:0] ST_RS_ADDR_R = 3'd4;
    localparam logic [2:0] ST_R_DATA    = 3'd5;
    localparam logic [2:0] ST_S_STOP    = 3'd6;
    localparam logic [2:0] ST_RESP      = 3'd7;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_NACK    = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;

    localparam logic I2C_WR_BIT = 1'b0;
    localparam logic I2C_RD_BIT = 1'b1;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev_addr;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } req_t;

    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
        return {dev, rd};
    endfunction

endpackage

// File: rtl/i2c_step_timer.sv
// Per-step watchdog: cleared whenever a new command is issued, counts while the
// sequencer waits, and flags expiry after TIMEOUT_CYCLES waiting cycles.
module i2c_step_timer #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q >= LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write request into START/WRITE/READ/STOP strobes for
// the byte-level I2C master and returns a single response per request.
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_write,
    output logic       m_read,
    output logic [7:0] m_data_in,
    output logic       m_ack_in,
    input  logic       m_done,
    input  logic       m_busy,
    input  logic       m_ack_err,
    input  logic [7:0] m_data_out
);

    logic [2:0] state_q, state_d;
    logic       phase_q, phase_d;
    req_t       req_q, req_d;
    logic [1:0] err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       m_start_q, m_start_d;
    logic       m_stop_q, m_stop_d;
    logic       m_write_q, m_write_d;
    logic       m_read_q, m_read_d;
    logic [7:0] m_data_in_q, m_data_in_d;
    logic       m_ack_in_q, m_ack_in_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0] rsp_err_q, rsp_err_d;

    logic       tmr_clear, tmr_en, tmr_expired;
    logic       issue_w, issue_start, issue_r;
    logic [7:0] issue_byte;
    logic [2:0] issue_state;
    logic       nack, tmo, go_stop, go_resp;

    i2c_step_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_start   = m_start_q;
    assign m_stop    = m_stop_q;
    assign m_write   = m_write_q;
    assign m_read    = m_read_q;
    assign m_data_in = m_data_in_q;
    assign m_ack_in  = m_ack_in_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        req_d       = req_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        m_start_d   = m_start_q;
        m_stop_d    = m_stop_q;
        m_write_d   = m_write_q;
        m_read_d    = 1'b0;
        m_data_in_d = m_data_in_q;
        m_ack_in_d  = m_ack_in_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;
        issue_w     = 1'b0;
        issue_start = 1'b0;
        issue_r     = 1'b0;
        issue_byte  = 8'h00;
        issue_state = ST_IDLE;
        nack        = 1'b0;
        tmo         = 1'b0;
        go_stop     = 1'b0;
        go_resp     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.rw       = req_rw;
                    req_d.dev_addr = req_dev_addr;
                    req_d.reg_addr = req_reg_addr;
                    req_d.wdata    = req_wdata;
                    err_d          = RSP_OK;
                    rdata_d        = 8'h00;
                    m_ack_in_d     = 1'b0;
                    issue_w        = 1'b1;
                    issue_start    = 1'b1;
                    issue_byte     = addr_byte(req_dev_addr, I2C_WR_BIT);
                    issue_state    = ST_S_ADDR_W;
                end
            end
            ST_S_ADDR_W: begin
                tmr_en = 1'b1;
                // START is held until the master reports the bus as taken.
                if (!phase_q && m_busy) begin
                    m_start_d = 1'b0;
                    m_write_d = 1'b0;
                    phase_d   = 1'b1;
                end
                if (m_done) begin
                    if (m_ack_err) begin
                        nack = 1'b1;
                    end else begin
                        issue_w     = 1'b1;
                        issue_byte  = req_q.reg_addr;
                        issue_state = ST_W_REG;
                    end
                end else if (tmr_expired) begin
                    tmo = 1'b1;
                end
            end
            ST_W_REG: begin
                tmr_en    = 1'b1;
                m_write_d = 1'b0;
                if (m_done) begin
                    if (m_ack_err) begin
                        nack = 1'b1;
                    end else if (req_q.rw == I2C_RD_BIT) begin
                        issue_w     = 1'b1;
                        issue_start = 1'b1;
                        issue_byte  = addr_byte(req_q.dev_addr, I2C_RD_BIT);
                        issue_state = ST_RS_ADDR_R;
                    end else begin
                        issue_w     = 1'b1;
                        issue_byte  = req_q.wdata;
                        issue_state = ST_W_DATA;
                    end
                end else if (tmr_expired) begin
                    tmo = 1'b1;
                end
            end
            ST_W_DATA: begin
                tmr_en    = 1'b1;
                m_write_d = 1'b0;
                if (m_done) begin
                    nack    = m_ack_err;
                    go_stop = 1'b1;
                end else if (tmr_expired) begin
                    tmo = 1'b1;
                end
            end
            ST_RS_ADDR_R: begin
                tmr_en = 1'b1;
                // Repeated START is held for exactly two cycles; the bus is already busy.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    m_start_d = 1'b0;
                    m_write_d = 1'b0;
                end
                if (m_done) begin
                    if (m_ack_err) begin
                        nack = 1'b1;
                    end else begin
                        issue_r = 1'b1;
                    end
                end else if (tmr_expired) begin
                    tmo = 1'b1;
                end
            end
            ST_R_DATA: begin
                tmr_en = 1'b1;
                if (m_done) begin
                    rdata_d = m_data_out;
                    go_stop = 1'b1;
                end else if (tmr_expired) begin
                    tmo = 1'b1;
                end
            end
            ST_S_STOP: begin
                tmr_en = 1'b1;
                if (!m_busy) begin
                    m_stop_d = 1'b0;
                    go_resp  = 1'b1;
                end else if (tmr_expired) begin
                    m_stop_d = 1'b0;
                    err_d    = RSP_TIMEOUT;
                    go_resp  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (nack) begin
            err_d   = RSP_NACK;
            go_stop = 1'b1;
        end
        if (tmo) begin
            if (err_q == RSP_OK) begin
                err_d = RSP_TIMEOUT;
            end
            go_stop = 1'b1;
        end

        if (issue_w) begin
            state_d     = issue_state;
            phase_d     = 1'b0;
            m_start_d   = issue_start;
            m_write_d   = 1'b1;
            m_data_in_d = issue_byte;
            tmr_clear   = 1'b1;
        end
        if (issue_r) begin
            state_d    = ST_R_DATA;
            m_start_d  = 1'b0;
            m_write_d  = 1'b0;
            m_read_d   = 1'b1;
            m_ack_in_d = 1'b1;
            tmr_clear  = 1'b1;
        end
        if (go_stop) begin
            state_d   = ST_S_STOP;
            m_start_d = 1'b0;
            m_write_d = 1'b0;
            m_stop_d  = 1'b1;
            tmr_clear = 1'b1;
        end
        if (go_resp) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_d;
            rsp_rdata_d = (err_d == RSP_OK && req_q.rw == I2C_RD_BIT) ? rdata_q : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            err_q       <= RSP_OK;
            rdata_q     <= 8'h00;
            m_start_q   <= 1'b0;
            m_stop_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_read_q    <= 1'b0;
            m_data_in_q <= 8'h00;
            m_ack_in_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= RSP_OK;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            m_start_q   <= m_start_d;
            m_stop_q    <= m_stop_d;
            m_write_q   <= m_write_d;
            m_read_q    <= m_read_d;
            m_data_in_q <= m_data_in_d;
            m_ack_in_q  <= m_ack_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
        req_q <= req_d;
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural byte-level master that
// logs every command byte, answers with done/ack_err and releases busy after STOP.
module tb_i2c_reg_sequencer;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       m_start, m_stop, m_write, m_read;
    logic [7:0] m_data_in;
    logic       m_ack_in;
    logic       m_done, m_busy, m_ack_err;
    logic [7:0] m_data_out;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(18)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_start(m_start), .m_stop(m_stop), .m_write(m_write), .m_read(m_read),
        .m_data_in(m_data_in), .m_ack_in(m_ack_in),
        .m_done(m_done), .m_busy(m_busy), .m_ack_err(m_ack_err), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int rsp_cnt  = 0;
    int acc_cnt  = 0;
    int stop_cnt = 0;
    logic [9:0] log_q[$];
    bit         silent   = 1'b0;
    int         nack_idx = 0;
    logic [7:0] rd_byte  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int n, input logic [9:0] e [6]);
        chk({tag, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), {22'd0, log_q[i]}, {22'd0, e[i]});
        end
    endtask

    // A new request may only be accepted once every earlier one has responded.
    always @(negedge clk) begin
        if (reset) begin
            acc_cnt = rsp_cnt;
        end else begin
            if (rsp_valid) rsp_cnt++;
            if (req_valid && req_ready) begin
                chk("accept_after_resp", rsp_cnt, acc_cnt);
                acc_cnt++;
            end
        end
    end

    // Master model. Log entry: bit9 = read, bit8 = start, [7:0] = byte (or ack_in for reads).
    initial begin
        int         mphase;
        int         dly;
        int         wbyte_idx;
        bit         cur_is_write;
        logic [7:0] cur_byte;
        mphase = 0; dly = 0; wbyte_idx = 0; cur_is_write = 1'b0; cur_byte = 8'h00;
        m_done = 1'b0; m_busy = 1'b0; m_ack_err = 1'b0; m_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            m_done    = 1'b0;
            m_ack_err = 1'b0;
            if (reset) begin
                mphase = 0; dly = 0; wbyte_idx = 0; m_busy = 1'b0;
            end else if (!silent) begin
                case (mphase)
                    0: begin
                        if (m_stop) begin
                            stop_cnt++;
                            mphase = 2; dly = 2;
                        end else if (m_start || m_write || m_read) begin
                            log_q.push_back({m_read, m_start, m_read ? {7'd0, m_ack_in} : m_data_in});
                            cur_is_write = m_write;
                            cur_byte     = m_data_in;
                            if (m_write) wbyte_idx++;
                            m_busy = 1'b1;
                            mphase = 1; dly = 3;
                        end
                    end
                    1: begin
                        dly--;
                        if (dly == 0) begin
                            m_done = 1'b1;
                            if (cur_is_write) begin
                                m_ack_err = (wbyte_idx == nack_idx);
                                chk("data_in_stable", m_data_in, cur_byte);
                            end else begin
                                m_data_out = rd_byte;
                                chk("ack_in_stable", m_ack_in, 1);
                            end
                            mphase = 0;
                        end
                    end
                    default: begin
                        dly--;
                        if (dly == 0) begin
                            m_busy = 1'b0; mphase = 0; wbyte_idx = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, output logic [1:0] err, output logic [7:0] rd);
        int n;
        int base;
        @(negedge clk);
        log_q.delete();
        base = rsp_cnt;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_rw = rw; req_dev_addr = dev; req_reg_addr = rg; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ready_drop", req_ready, 0);
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        chk("rsp_seen", rsp_valid, 1);
        err = rsp_err;
        rd  = rsp_rdata;
        repeat (3) @(negedge clk);
        chk("rsp_once", rsp_cnt, base + 1);
        chk("rdata_hold", rsp_rdata, rd);
    endtask

    initial begin
        logic [1:0] err;
        logic [7:0] rd;
        int cnt, n, base_stop, base_rsp, base_acc;
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
        req_dev_addr = 7'h00; req_reg_addr = 8'h00; req_wdata = 8'h00;

        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_strobes", {m_start, m_stop, m_write, m_read}, 0);
        chk("rst_data_ack", {m_data_in, m_ack_in}, 0);
        chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        base_stop = stop_cnt;
        do_req(1'b0, 7'h50, 8'h10, 8'hAA, err, rd);
        chk("wr_err", err, 0);
        chk("wr_rdata", rd, 8'h00);
        chk("wr_stop", stop_cnt - base_stop, 1);
        check_log("wr", 3, '{10'h1A0, 10'h010, 10'h0AA, 10'h0, 10'h0, 10'h0});

        rd_byte = 8'h5C;
        base_stop = stop_cnt;
        do_req(1'b1, 7'h50, 8'h22, 8'h00, err, rd);
        chk("rd_err", err, 0);
        chk("rd_rdata", rd, 8'h5C);
        chk("rd_stop", stop_cnt - base_stop, 1);
        check_log("rd", 4, '{10'h1A0, 10'h022, 10'h1A1, 10'h201, 10'h0, 10'h0});

        nack_idx = 2;
        base_stop = stop_cnt;
        do_req(1'b0, 7'h50, 8'h33, 8'h77, err, rd);
        nack_idx = 0;
        chk("nack_err", err, 1);
        chk("nack_rdata", rd, 8'h00);
        chk("nack_stop", stop_cnt - base_stop, 1);
        check_log("nack", 2, '{10'h1A0, 10'h033, 10'h0, 10'h0, 10'h0, 10'h0});

        silent = 1'b1;
        log_q.delete();
        @(negedge clk);
        chk("tmo_ready", req_ready, 1);
        req_rw = 1'b0; req_dev_addr = 7'h50; req_reg_addr = 8'h10; req_wdata = 8'h01;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0; n = 0;
        while (!m_stop && n < 500) begin
            if (m_start) cnt++;
            @(negedge clk);
            n++;
        end
        chk("tmo_start_cycles", cnt, TMO);
        chk("tmo_stop", m_stop, 1);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("tmo_rsp", rsp_valid, 1);
        chk("tmo_err", rsp_err, 2);
        chk("tmo_rdata", rsp_rdata, 8'h00);
        @(negedge clk);
        chk("tmo_idle_ready", req_ready, 1);
        chk("tmo_no_bytes", log_q.size(), 0);
        silent = 1'b0;

        @(negedge clk);
        req_rw = 1'b0; req_dev_addr = 7'h50; req_reg_addr = 8'h10; req_wdata = 8'hAA;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(m_write && !m_start && m_data_in == 8'hAA) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_wdata", {m_write, m_data_in}, {1'b1, 8'hAA});
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_strobes", {m_start, m_stop, m_write, m_read}, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", req_ready, 1);
        do_req(1'b0, 7'h3C, 8'h01, 8'h5A, err, rd);
        chk("post_rst_err", err, 0);
        check_log("post_rst", 3, '{10'h178, 10'h001, 10'h05A, 10'h0, 10'h0, 10'h0});

        @(negedge clk);
        log_q.delete();
        base_rsp = rsp_cnt;
        base_acc = acc_cnt;
        req_rw = 1'b0; req_dev_addr = 7'h21; req_reg_addr = 8'h02; req_wdata = 8'h03;
        req_valid = 1'b1;
        cnt = 0; n = 0;
        while (cnt < 2 && n < 3000) begin
            @(negedge clk);
            n++;
            if (rsp_valid) cnt++;
        end
        req_valid = 1'b0;
        chk("b2b_err", rsp_err, 0);
        repeat (4) @(negedge clk);
        chk("b2b_rsp_count", rsp_cnt - base_rsp, 2);
        chk("b2b_acc_count", acc_cnt - base_acc, 2);
        check_log("b2b", 6, '{10'h142, 10'h002, 10'h003, 10'h142, 10'h002, 10'h003});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Command sequencer that sits directly upstream of the I2C byte-level master (top_i2c / i2c_master). It turns a single register-access request (device address, register address, write data or read) into the master's START/WRITE/READ/STOP command pulses. It tracks done/ack_err per byte and returns one response per request. Used by the game logic to access I2C peripherals without handling byte-level protocol.

Parameters:
TIMEOUT_CYCLES, 200000, max clk cycles to wait for m_done (or m_busy edge) per step before aborting
CNT_W, 18, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request (high only in IDLE)
req_rw  in  1  0 = write, 1 = read
req_dev_addr  in  7  7-bit slave address
req_reg_addr  in  8  register address
req_wdata  in  8  write data (ignored on read)
rsp_valid  out  1  one-cycle pulse: response available
rsp_rdata  out  8  read byte (0x00 on write or error)
rsp_err  out  2  0 = OK, 1 = NACK (ack_err), 2 = timeout
m_start, m_stop, m_write, m_read  out  1 each  command strobes to master
m_data_in  out  8  byte for master to transmit
m_ack_in  out  1  ACK bit master sends after a read (1 = NACK)
m_done  in  1  master byte-complete pulse
m_busy  in  1  master bus-busy level
m_ack_err  in  1  slave NACKed last written byte (valid with m_done)
m_data_out  in  8  byte read by master (valid with m_done)

Behaviour:
- Single clock. Reset is synchronous and active-high: on reset, state=IDLE, all m_* strobes=0, m_data_in=0, m_ack_in=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 for the reset cycle and 1 afterwards. Reset mid-transaction drops all strobes immediately; the master is reset by the same signal.
- Accept: req_valid & req_ready. Capture all req_* fields and drop req_ready the next cycle.
- States: IDLE, S_ADDR_W, W_REG, W_DATA, RS_ADDR_R, R_DATA, S_STOP, RESP.
- S_ADDR_W: hold m_start=m_write=1 with m_data_in={dev,1'b0} until m_busy=1, then drop both and wait for m_done.
- W_REG: one-cycle m_write pulse with reg_addr; wait for m_done.
- Write path: W_REG -> W_DATA (one-cycle m_write pulse with wdata; wait m_done) -> S_STOP.
- Read path: W_REG -> RS_ADDR_R. Repeated start: m_start=m_write=1, m_data_in={dev,1'b1}, held exactly 2 cycles; wait m_done. Then R_DATA: one-cycle m_read pulse with m_ack_in=1 (NACK, single byte); on m_done latch m_data_out into rsp_rdata.
- m_data_in and m_ack_in stay stable from the strobe until m_done.
- If m_done arrives with m_ack_err=1 after any written byte: set err=1, skip remaining bytes, go to S_STOP.
- Timeout: counter clears at each strobe issue and counts while waiting. Reaching TIMEOUT_CYCLES sets err=2 (if err not already set) and forces S_STOP.
- S_STOP: hold m_stop=1 until m_busy=0, then RESP. Bounded by the same timeout; if it expires, go to RESP with err=2.
- RESP: rsp_valid=1 for exactly one cycle with rsp_err/rsp_rdata, then IDLE. rsp_rdata/rsp_err hold their value until the next RESP.
- m_done seen outside a waiting state is ignored.
- Latency (write, ideal master): response follows 3 m_done pulses plus stop release plus 1 cycle.

Decomposition:
- Shared package i2c_pkg: state encoding constants, RSP_OK/RSP_NACK/RSP_TIMEOUT codes, I2C_WR_BIT=0, I2C_RD_BIT=1.
- Sub-module i2c_step_timer: loadable timeout counter (clear, enable, expired flag). All other logic stays in a single FSM.

Test Plan:
- Write dev=0x50, reg=0x10, data=0xAA with ACKing slave -> master sees bytes 0xA0, 0x10, 0xAA, then STOP; rsp_valid once, rsp_err=0, rsp_rdata=0x00.
- Read dev=0x50, reg=0x22, slave returns 0x5C -> bytes 0xA0, 0x22, RS, 0xA1; m_read with m_ack_in=1; rsp_rdata=0x5C, rsp_err=0.
- Slave NACKs reg byte (m_ack_err=1 on 2nd done) -> no 3rd byte, STOP issued, rsp_err=1.
- Master never returns m_done, TIMEOUT_CYCLES=50 -> stop issued after 50 wait cycles, rsp_err=2, then back to IDLE with req_ready=1.
- Reset asserted during W_DATA -> next cycle all strobes 0, rsp_valid 0; a following write request completes normally with rsp_err=0.
- Back-to-back requests with req_valid held -> second request accepted only after RESP; exactly one rsp_valid per request.
